// File: rtl/seq_addtree_mul.sv
`default_nettype none
// ============================================================================
// Module   : seq_addtree_mul
// Brief    : Multi-cycle shift-and-add multiplier. Each BUSY cycle retires
//            BITS_PER_CYCLE multiplier bits through a balanced add tree.
//            Operands and the product use valid/ready handshakes.
//            Optional macro MUL_SIGNED_EN adds two's-complement support
//            (magnitude multiply followed by a conditional negate).
// Revision : 1.0 - initial release
// ============================================================================
module seq_addtree_mul #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mul_a,
    input  logic [WIDTH-1:0]     mul_b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   mul_out,
    output logic                 busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_BUSY = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    generate
        if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4)
            || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
            $fatal(1, "seq_addtree_mul: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_in_ready;
    logic [PW-1:0]    r_a;
    logic [WIDTH-1:0] r_b;
    logic [PW-1:0]    r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_prod;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [PW-1:0]    w_sum;
    logic [PW-1:0]    w_acc_next;
    logic [PW-1:0]    w_prod_final;
    logic             w_accept;
    logic             w_last;

    assign w_accept   = in_valid && r_in_ready;
    assign w_last     = (r_cnt == CNT_W'(1));
    assign w_acc_next = r_acc + w_sum;

`ifdef MUL_SIGNED_EN
    logic r_neg;
    logic w_neg_in;

    // Magnitudes of -2^(W-1) wrap to 2^(W-1), which is still correct unsigned.
    assign w_a_mag      = (is_signed && mul_a[WIDTH-1]) ? -mul_a : mul_a;
    assign w_b_mag      = (is_signed && mul_b[WIDTH-1]) ? -mul_b : mul_b;
    assign w_neg_in     = is_signed && (mul_a[WIDTH-1] ^ mul_b[WIDTH-1]);
    assign w_prod_final = r_neg ? -w_acc_next : w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= w_neg_in;
        end
    end
`else
    logic w_unused_is_signed;

    assign w_unused_is_signed = is_signed;
    assign w_a_mag            = mul_a;
    assign w_b_mag            = mul_b;
    assign w_prod_final       = w_acc_next;
`endif

    // Multiplicand register is pre-shifted, so pp[k] already sits at the
    // current accumulator offset.
    logic [PW-1:0] w_pp [BITS_PER_CYCLE];

    generate
        for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_pp
            assign w_pp[k] = r_b[k] ? (r_a << k) : '0;
        end

        if (BITS_PER_CYCLE == 1) begin : g_tree1
            assign w_sum = w_pp[0];
        end else if (BITS_PER_CYCLE == 2) begin : g_tree2
            assign w_sum = w_pp[0] + w_pp[1];
        end else begin : g_tree4
            logic [PW-1:0] w_s0;
            logic [PW-1:0] w_s1;
            assign w_s0  = w_pp[0] + w_pp[1];
            assign w_s1  = w_pp[2] + w_pp[3];
            assign w_sum = w_s0 + w_s1;
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_IDLE:  if (w_accept)  w_state_next = C_BUSY;
            C_BUSY:  if (w_last)    w_state_next = C_DONE;
            C_DONE:  if (out_ready) w_state_next = C_IDLE;
            default:                w_state_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= C_IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == C_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_prod <= '0;
        end else if (w_accept) begin
            r_a   <= PW'(w_a_mag);
            r_b   <= w_b_mag;
            r_acc <= '0;
            r_cnt <= CNT_W'(N);
        end else if (r_state == C_BUSY) begin
            r_a   <= r_a << BITS_PER_CYCLE;
            r_b   <= r_b >> BITS_PER_CYCLE;
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_prod <= w_prod_final;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = (r_state == C_BUSY);
    assign out_valid = (r_state == C_DONE);
    assign mul_out   = r_prod;

endmodule
`default_nettype wire

// File: tb/tb_seq_addtree_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_addtree_mul
// Brief    : Directed self-checking bench; runs BITS_PER_CYCLE = 1, 2 and 4
//            instances side by side on shared operand/handshake inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_addtree_mul;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        is_signed;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;

    logic        rdy1, rdy2, rdy4;
    logic        ov1, ov2, ov4;
    logic        busy1, busy2, busy4;
    logic [15:0] out1, out2, out4;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_addtree_mul #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .mul_a(mul_a), .mul_b(mul_b), .is_signed(is_signed),
        .out_valid(ov1), .out_ready(out_ready), .mul_out(out1), .busy(busy1));

    seq_addtree_mul #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .mul_a(mul_a), .mul_b(mul_b), .is_signed(is_signed),
        .out_valid(ov2), .out_ready(out_ready), .mul_out(out2), .busy(busy2));

    seq_addtree_mul #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
        .mul_a(mul_a), .mul_b(mul_b), .is_signed(is_signed),
        .out_valid(ov4), .out_ready(out_ready), .mul_out(out4), .busy(busy4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; issues one operand pair with out_ready=1.
    task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                          input logic [15:0] exp, input string tag);
        int lat1 = 0;
        int lat2 = 0;
        int lat4 = 0;
        int guard = 0;
        logic [15:0] p1 = '0;
        logic [15:0] p2 = '0;
        logic [15:0] p4 = '0;
        while (!(rdy1 && rdy2 && rdy4) && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, " ready"}, {29'd0, rdy1, rdy2, rdy4}, 32'd7);
        mul_a = a; mul_b = b; is_signed = sgn; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " busy"}, {29'd0, busy1, busy2, busy4}, 32'd7);
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            if (lat2 != 0 && e == lat2 + 1) begin
                check({tag, " in_ready after out handshake"}, {30'd0, rdy2, ov2}, 32'd2);
            end
            if (ov1 && lat1 == 0) begin lat1 = e; p1 = out1; end
            if (ov2 && lat2 == 0) begin
                lat2 = e; p2 = out2;
                check({tag, " in_ready while out_valid"}, {31'd0, rdy2}, 32'd0);
            end
            if (ov4 && lat4 == 0) begin lat4 = e; p4 = out4; end
        end
        check({tag, " latency bpc1"}, lat1, 32'd8);
        check({tag, " latency bpc2"}, lat2, 32'd4);
        check({tag, " latency bpc4"}, lat4, 32'd2);
        check({tag, " product bpc1"}, {16'd0, p1}, {16'd0, exp});
        check({tag, " product bpc2"}, {16'd0, p2}, {16'd0, exp});
        check({tag, " product bpc4"}, {16'd0, p4}, {16'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] va [8];
    logic [7:0] vb [8];
    logic       seen;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        is_signed = 1'b0; mul_a = '0; mul_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", {31'd0, rdy2}, 32'd0);
        check("reset out_valid", {29'd0, ov1, ov2, ov4}, 32'd0);
        check("reset busy", {29'd0, busy1, busy2, busy4}, 32'd0);
        check("reset mul_out", {16'd0, out2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready first edge after release", {29'd0, rdy1, rdy2, rdy4}, 32'd7);

        do_mul(8'd13,  8'd11,  1'b0, 16'd143,  "13x11");
        do_mul(8'd255, 8'd255, 1'b0, 16'hFE01, "255x255");
        do_mul(8'd0,   8'd200, 1'b0, 16'h0000, "0x200");

        // Backpressure on 7*9 with ignored 1*1 offers.
        out_ready = 1'b0;
        mul_a = 8'd7; mul_b = 8'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp out_valid rise", {31'd0, ov2}, 32'd1);
        check("bp product", {16'd0, out2}, 32'd63);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0); mul_a = 8'd1; mul_b = 8'd1;
            @(posedge clk); #1;
            check("bp hold out_valid", {31'd0, ov2}, 32'd1);
            check("bp hold product", {16'd0, out2}, 32'd63);
            check("bp in_ready low", {31'd0, rdy2}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release out_valid", {31'd0, ov2}, 32'd0);
        check("bp release in_ready", {31'd0, rdy2}, 32'd1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ov2) seen = 1'b1;
        end
        check("bp no second result", {31'd0, seen}, 32'd0);

`ifdef MUL_SIGNED_EN
        do_mul(8'hCE, 8'h32, 1'b1, 16'hF63C, "signed -50x50");
`else
        do_mul(8'hCE, 8'h32, 1'b1, 16'h283C, "unsigned 0xCE x 0x32");
`endif
        do_mul(8'h80, 8'h80, 1'b1, 16'h4000, "-128x-128");

        // Abort two edges into BUSY.
        mul_a = 8'd200; mul_b = 8'd100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort out_valid", {29'd0, ov1, ov2, ov4}, 32'd0);
        check("abort busy", {29'd0, busy1, busy2, busy4}, 32'd0);
        check("abort mul_out", {out2, out4}, 32'd0);
        check("abort in_ready", {31'd0, rdy2}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_mul(8'd3, 8'd3, 1'b0, 16'd9, "3x3 after abort");

        va = '{8'd1, 8'd255, 8'd128, 8'd170, 8'd85, 8'd16, 8'd99, 8'd254};
        vb = '{8'd255, 8'd1, 8'd2, 8'd85, 8'd170, 8'd16, 8'd201, 8'd3};
        for (int i = 0; i < 8; i++) begin
            do_mul(va[i], vb[i], 1'b0, 16'(va[i]) * 16'(vb[i]), $sformatf("vec%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
